// File: rtl/rf80386_fta_arbiter_pkg.sv
// FTA bus types and arbiter-local definitions shared by the rf80386 FTA
// arbiter, its skid buffer and its interface.
package rf80386_fta_arbiter_pkg;

  typedef enum logic [4:0] {
    CMD_NONE        = 5'd0,
    CMD_LOAD        = 5'd1,
    CMD_LOADZ       = 5'd2,
    CMD_STORE       = 5'd3,
    CMD_ICACHE_LOAD = 5'd4
  } fta_cmd_t;

  typedef struct packed {
    logic [5:0] core;
    logic [2:0] channel;
    logic [6:0] tranid;
  } fta_tranid_t;

  typedef struct packed {
    fta_cmd_t     cmd;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  padr;
    logic [127:0] data1;
    fta_tranid_t  tid;
  } fta_cmd_request128_t;

  typedef struct packed {
    fta_tranid_t  tid;
    logic         ack;
    logic         err;
    logic         rty;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;

  typedef enum logic {
    FTA_CH_IC = 1'b0,
    FTA_CH_DC = 1'b1
  } fta_chan_e;

  localparam int FTA_MAX_OUT_DEFAULT = 4;

  function automatic logic req_valid(fta_cmd_request128_t r);
    return r.cyc && (r.cmd != CMD_NONE);
  endfunction

  // rty closes the transaction just like ack/err; the requester reissues.
  function automatic logic resp_done(fta_cmd_response128_t r);
    return r.ack | r.err | r.rty;
  endfunction

endpackage

// File: rtl/rf80386_fta_arbiter_if.sv
// Bundle of the arbiter's requester, master-port and status signals.
// slave is the arbiter's view; master is the surrounding core/bus view.
interface rf80386_fta_arbiter_if;
  import rf80386_fta_arbiter_pkg::*;

  fta_cmd_request128_t  ic_req_i;
  fta_cmd_response128_t ic_resp_o;
  logic                 ic_busy_o;
  fta_cmd_request128_t  dc_req_i;
  fta_cmd_response128_t dc_resp_o;
  logic                 dc_busy_o;
  fta_cmd_request128_t  ftam_req;
  fta_cmd_response128_t ftam_resp;
  logic [7:0]           stray_cnt_o;

  modport slave (
    input  ic_req_i, dc_req_i, ftam_resp,
    output ic_resp_o, ic_busy_o, dc_resp_o, dc_busy_o, ftam_req, stray_cnt_o
  );

  modport master (
    output ic_req_i, dc_req_i, ftam_resp,
    input  ic_resp_o, ic_busy_o, dc_resp_o, dc_busy_o, ftam_req, stray_cnt_o
  );

endinterface

// File: rtl/rf80386_fta_arbiter_skid.sv
// One-entry request buffer. An incoming pulse is offered straight to the
// arbiter; it is stored only when it is not taken on the same edge.
module rf80386_fta_skid
  import rf80386_fta_arbiter_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  fta_cmd_request128_t req,
  input  logic                take,
  output logic                pending,
  output fta_cmd_request128_t entry,
  output logic                full
);

  fta_cmd_request128_t entry_q;
  logic                full_q;
  logic                in_vld;

  assign in_vld  = req_valid(req);
  assign pending = full_q | in_vld;
  assign entry   = full_q ? entry_q : req;
  assign full    = full_q;

  // A pulse that arrives while full is a requester error and is discarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else if (full_q) begin
      if (take) full_q <= 1'b0;
    end else if (in_vld && !take) begin
      full_q  <= 1'b1;
      entry_q <= req;
    end
  end

endmodule

// File: rtl/rf80386_fta_arbiter.sv
// Round-robin arbiter sharing one 128-bit FTA master port between the
// instruction-fill and data channels, with per-channel outstanding limits.
module rf80386_fta_arbiter
  import rf80386_fta_arbiter_pkg::*;
#(
  parameter logic [5:0] CORENO  = 6'd1,
  parameter logic [2:0] IC_CID  = 3'd0,
  parameter logic [2:0] DC_CID  = 3'd1,
  parameter int         MAX_OUT = FTA_MAX_OUT_DEFAULT
) (
  input logic clk_i,
  input logic rst_i,
  rf80386_fta_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  logic ic_pend, dc_pend, ic_full, dc_full, ic_take, dc_take;
  logic ic_elig, dc_elig;
  fta_cmd_request128_t ic_entry, dc_entry;
  logic [3:0] ic_cnt_q, dc_cnt_q;
  fta_chan_e last_grant_q;
  fta_cmd_request128_t  req_q;
  fta_cmd_response128_t ic_resp_q, dc_resp_q;
  logic [7:0] stray_q;
  logic resp_ic, resp_dc, resp_fin, ic_dec, dc_dec;

  rf80386_fta_skid u_ic_skid (
    .clk_i(clk_i), .rst_i(rst_i), .req(bus.ic_req_i), .take(ic_take),
    .pending(ic_pend), .entry(ic_entry), .full(ic_full)
  );

  rf80386_fta_skid u_dc_skid (
    .clk_i(clk_i), .rst_i(rst_i), .req(bus.dc_req_i), .take(dc_take),
    .pending(dc_pend), .entry(dc_entry), .full(dc_full)
  );

  assign ic_elig = ic_pend && (ic_cnt_q < MAX_CNT);
  assign dc_elig = dc_pend && (dc_cnt_q < MAX_CNT);
  // On a tie the channel that did not win last time goes first.
  assign dc_take = dc_elig && (!ic_elig || (last_grant_q == FTA_CH_IC));
  assign ic_take = ic_elig && !dc_take;

  assign resp_ic  = (bus.ftam_resp.tid.core == CORENO) && (bus.ftam_resp.tid.channel == IC_CID);
  assign resp_dc  = (bus.ftam_resp.tid.core == CORENO) && (bus.ftam_resp.tid.channel == DC_CID)
                    && !resp_ic;
  assign resp_fin = resp_done(bus.ftam_resp);
  assign ic_dec   = resp_ic && resp_fin;
  assign dc_dec   = resp_dc && resp_fin;

  function automatic fta_cmd_request128_t stamp(fta_cmd_request128_t r, logic [2:0] cid);
    fta_cmd_request128_t s;
    s             = r;
    s.tid.core    = CORENO;
    s.tid.channel = cid;
    return s;
  endfunction

  // Underflow (response with nothing outstanding) leaves the count at zero.
  function automatic logic [3:0] next_cnt(logic [3:0] c, logic inc, logic dec);
    if (inc && !dec) return c + 4'd1;
    if (dec && !inc && (c != 4'd0)) return c - 4'd1;
    return c;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q        <= '0;
      ic_resp_q    <= '0;
      dc_resp_q    <= '0;
      ic_cnt_q     <= 4'd0;
      dc_cnt_q     <= 4'd0;
      stray_q      <= 8'd0;
      last_grant_q <= FTA_CH_IC;
    end else begin
      if (ic_take) begin
        req_q        <= stamp(ic_entry, IC_CID);
        last_grant_q <= FTA_CH_IC;
      end else if (dc_take) begin
        req_q        <= stamp(dc_entry, DC_CID);
        last_grant_q <= FTA_CH_DC;
      end else begin
        req_q <= '0;
      end
      ic_cnt_q  <= next_cnt(ic_cnt_q, ic_take, ic_dec);
      dc_cnt_q  <= next_cnt(dc_cnt_q, dc_take, dc_dec);
      ic_resp_q <= resp_ic ? bus.ftam_resp : '0;
      dc_resp_q <= resp_dc ? bus.ftam_resp : '0;
      if (!resp_ic && !resp_dc && resp_fin && (stray_q != 8'hFF))
        stray_q <= stray_q + 8'd1;
    end
  end

  assign bus.ftam_req    = req_q;
  assign bus.ic_resp_o   = ic_resp_q;
  assign bus.dc_resp_o   = dc_resp_q;
  assign bus.ic_busy_o   = ic_full;
  assign bus.dc_busy_o   = dc_full;
  assign bus.stray_cnt_o = stray_q;

endmodule

// File: tb/tb_rf80386_fta_arbiter.sv
// Self-checking bench for rf80386_fta_arbiter: scenario tasks plus a
// master-port scoreboard fed by the stimulus.
module tb_rf80386_fta_arbiter;
  import rf80386_fta_arbiter_pkg::*;

  localparam int         REQ_W  = $bits(fta_cmd_request128_t);
  localparam logic [5:0] CORENO = 6'd1;
  localparam logic [2:0] IC_CID = 3'd0;
  localparam logic [2:0] DC_CID = 3'd1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [REQ_W-1:0] exp_q[$];
  logic [REQ_W-1:0] sb_exp;

  rf80386_fta_arbiter_if arb_if ();

  rf80386_fta_arbiter dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (arb_if)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: every issued master request must be the next expected one.
  always @(posedge clk_i) begin
    #2;
    if (arb_if.ftam_req.cyc) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %h, required no request", arb_if.ftam_req);
      end else begin
        sb_exp = exp_q.pop_front();
        if (arb_if.ftam_req !== sb_exp) begin
          fails++;
          $display("FAIL sb_request: got %h, required %h", arb_if.ftam_req, sb_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic fta_cmd_request128_t mk_req(fta_cmd_t cmd, logic [6:0] tr, logic [31:0] adr);
    fta_cmd_request128_t r;
    r             = '0;
    r.cmd         = cmd;
    r.cyc         = 1'b1;
    r.stb         = 1'b1;
    r.we          = (cmd == CMD_STORE);
    r.sel         = 16'hFFFF;
    r.padr        = adr;
    r.data1       = {adr, ~adr, adr, ~adr};
    r.tid.core    = 6'h3F;
    r.tid.channel = 3'h7;
    r.tid.tranid  = tr;
    return r;
  endfunction

  function automatic logic [REQ_W-1:0] exp_req(fta_cmd_request128_t r, logic [2:0] cid);
    r.tid.core    = CORENO;
    r.tid.channel = cid;
    return r;
  endfunction

  function automatic fta_cmd_response128_t mk_resp(logic [5:0] core, logic [2:0] ch, logic [6:0] tr,
                                                   logic ack, logic err, logic [127:0] dat);
    fta_cmd_response128_t p;
    p             = '0;
    p.tid.core    = core;
    p.tid.channel = ch;
    p.tid.tranid  = tr;
    p.ack         = ack;
    p.err         = err;
    p.adr         = 32'h1000_0000 | 32'(tr);
    p.dat         = dat;
    return p;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    arb_if.ic_req_i  = '0;
    arb_if.dc_req_i  = '0;
    arb_if.ftam_resp = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    tests++; if (arb_if.ftam_req !== '0) begin fails++; $display("FAIL rst_ftam_req: got %h, required 0", arb_if.ftam_req); end
    tests++; if (arb_if.ic_resp_o !== '0) begin fails++; $display("FAIL rst_ic_resp: got %h, required 0", arb_if.ic_resp_o); end
    tests++; if (arb_if.dc_resp_o !== '0) begin fails++; $display("FAIL rst_dc_resp: got %h, required 0", arb_if.dc_resp_o); end
    tests++; if ({arb_if.ic_busy_o, arb_if.dc_busy_o} !== 2'b00) begin fails++; $display("FAIL rst_busy: got %b%b, required 00", arb_if.ic_busy_o, arb_if.dc_busy_o); end
    tests++; if (arb_if.stray_cnt_o !== 8'd0) begin fails++; $display("FAIL rst_stray: got %0d, required 0", arb_if.stray_cnt_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_single_ic();
    fta_cmd_request128_t r;
    logic [REQ_W-1:0] e;
    do_reset();
    r = mk_req(CMD_LOAD, 7'd3, 32'h0000_4000);
    e = exp_req(r, IC_CID);
    arb_if.ic_req_i = r;
    exp_q.push_back(e);
    step();
    tests++; if (arb_if.ftam_req !== e) begin fails++; $display("FAIL single_ic_grant: got %h, required %h", arb_if.ftam_req, e); end
    tests++; if (arb_if.ftam_req.tid.tranid !== 7'd3) begin fails++; $display("FAIL single_ic_tranid: got %0d, required 3", arb_if.ftam_req.tid.tranid); end
    step();
    tests++; if (arb_if.ftam_req !== '0) begin fails++; $display("FAIL single_ic_idle: got %h, required 0", arb_if.ftam_req); end
  endtask

  task automatic test_tie();
    fta_cmd_request128_t ri, rd;
    do_reset();
    ri = mk_req(CMD_ICACHE_LOAD, 7'd1, 32'h0000_0100);
    rd = mk_req(CMD_STORE, 7'd2, 32'h0000_0200);
    arb_if.ic_req_i = ri; arb_if.dc_req_i = rd;
    exp_q.push_back(exp_req(rd, DC_CID)); exp_q.push_back(exp_req(ri, IC_CID));
    step();
    tests++; if (arb_if.ftam_req.tid.channel !== DC_CID) begin fails++; $display("FAIL tie1_first: got ch %0d, required %0d", arb_if.ftam_req.tid.channel, DC_CID); end
    tests++; if (arb_if.ic_busy_o !== 1'b1) begin fails++; $display("FAIL tie1_ic_busy: got %b, required 1", arb_if.ic_busy_o); end
    step();
    tests++; if (arb_if.ftam_req.tid.channel !== IC_CID || arb_if.ftam_req.cyc !== 1'b1) begin fails++; $display("FAIL tie1_second: got ch %0d cyc %b, required ch %0d cyc 1", arb_if.ftam_req.tid.channel, arb_if.ftam_req.cyc, IC_CID); end
    tests++; if (arb_if.ic_busy_o !== 1'b0) begin fails++; $display("FAIL tie1_ic_free: got %b, required 0", arb_if.ic_busy_o); end
    rd = mk_req(CMD_LOAD, 7'd4, 32'h0000_0300);
    arb_if.dc_req_i = rd;
    exp_q.push_back(exp_req(rd, DC_CID));
    step();
    ri = mk_req(CMD_LOAD, 7'd5, 32'h0000_0400);
    rd = mk_req(CMD_LOAD, 7'd6, 32'h0000_0500);
    arb_if.ic_req_i = ri; arb_if.dc_req_i = rd;
    exp_q.push_back(exp_req(ri, IC_CID)); exp_q.push_back(exp_req(rd, DC_CID));
    step();
    tests++; if (arb_if.ftam_req.tid.channel !== IC_CID || arb_if.ftam_req.cyc !== 1'b1) begin fails++; $display("FAIL tie2_first: got ch %0d cyc %b, required ch %0d cyc 1", arb_if.ftam_req.tid.channel, arb_if.ftam_req.cyc, IC_CID); end
    step();
    tests++; if (arb_if.ftam_req.tid.channel !== DC_CID || arb_if.ftam_req.cyc !== 1'b1) begin fails++; $display("FAIL tie2_second: got ch %0d cyc %b, required ch %0d cyc 1", arb_if.ftam_req.tid.channel, arb_if.ftam_req.cyc, DC_CID); end
    step();
  endtask

  task automatic test_out_limit();
    fta_cmd_request128_t r;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      r = mk_req(CMD_LOAD, 7'(10 + i), 32'h0000_1000 + 32'(i * 16));
      arb_if.dc_req_i = r;
      exp_q.push_back(exp_req(r, DC_CID));
      step();
    end
    tests++; if (arb_if.ftam_req.cyc !== 1'b0) begin fails++; $display("FAIL limit_held: got cyc %b, required 0", arb_if.ftam_req.cyc); end
    tests++; if (arb_if.dc_busy_o !== 1'b1) begin fails++; $display("FAIL limit_busy: got %b, required 1", arb_if.dc_busy_o); end
    step();
    step();
    tests++; if (arb_if.dc_busy_o !== 1'b1 || arb_if.ftam_req.cyc !== 1'b0) begin fails++; $display("FAIL limit_still_held: got busy %b cyc %b, required busy 1 cyc 0", arb_if.dc_busy_o, arb_if.ftam_req.cyc); end
    arb_if.ftam_resp = mk_resp(CORENO, DC_CID, 7'd10, 1'b1, 1'b0, {4{32'hDEAD_0010}});
    step();
    tests++; if (arb_if.dc_resp_o.ack !== 1'b1 || arb_if.ftam_req.cyc !== 1'b0) begin fails++; $display("FAIL limit_ack_seen: got ack %b cyc %b, required ack 1 cyc 0", arb_if.dc_resp_o.ack, arb_if.ftam_req.cyc); end
    step();
    tests++; if (arb_if.ftam_req.cyc !== 1'b1 || arb_if.ftam_req.tid.tranid !== 7'd14) begin fails++; $display("FAIL limit_release: got cyc %b tranid %0d, required cyc 1 tranid 14", arb_if.ftam_req.cyc, arb_if.ftam_req.tid.tranid); end
    tests++; if (arb_if.dc_busy_o !== 1'b0) begin fails++; $display("FAIL limit_unbusy: got %b, required 0", arb_if.dc_busy_o); end
    step();
  endtask

  task automatic test_routing();
    fta_cmd_response128_t p;
    do_reset();
    p = mk_resp(CORENO, IC_CID, 7'd7, 1'b1, 1'b0, {16{8'hA5}});
    arb_if.ftam_resp = p;
    step();
    tests++; if (arb_if.ic_resp_o !== p) begin fails++; $display("FAIL route_ic: got %h, required %h", arb_if.ic_resp_o, p); end
    tests++; if (arb_if.dc_resp_o !== '0) begin fails++; $display("FAIL route_ic_other: got %h, required 0", arb_if.dc_resp_o); end
    p = mk_resp(CORENO, DC_CID, 7'd8, 1'b0, 1'b1, {4{32'h5A5A_1234}});
    arb_if.ftam_resp = p;
    step();
    tests++; if (arb_if.dc_resp_o !== p || arb_if.ic_resp_o !== '0) begin fails++; $display("FAIL route_dc_err: got dc %h, required %h", arb_if.dc_resp_o, p); end
    arb_if.ftam_resp = mk_resp(6'd2, IC_CID, 7'd9, 1'b1, 1'b0, {16{8'h11}});
    step();
    tests++; if (arb_if.ic_resp_o !== '0 || arb_if.dc_resp_o !== '0) begin fails++; $display("FAIL stray_core_zero: got ic %h dc %h, required both 0", arb_if.ic_resp_o, arb_if.dc_resp_o); end
    tests++; if (arb_if.stray_cnt_o !== 8'd1) begin fails++; $display("FAIL stray_core_cnt: got %0d, required 1", arb_if.stray_cnt_o); end
    arb_if.ftam_resp = mk_resp(CORENO, 3'd5, 7'd9, 1'b1, 1'b0, {16{8'h22}});
    step();
    tests++; if (arb_if.stray_cnt_o !== 8'd2) begin fails++; $display("FAIL stray_chan_cnt: got %0d, required 2", arb_if.stray_cnt_o); end
    arb_if.ftam_resp = mk_resp(6'd2, 3'd5, 7'd9, 1'b0, 1'b0, {16{8'h33}});
    step();
    tests++; if (arb_if.stray_cnt_o !== 8'd2) begin fails++; $display("FAIL stray_idle: got %0d, required 2", arb_if.stray_cnt_o); end
    for (int i = 0; i < 300; i++) begin
      arb_if.ftam_resp = mk_resp(6'($urandom_range(2, 63)), 3'($urandom_range(0, 7)),
                                 7'($urandom_range(0, 127)), 1'b1, 1'b0, {4{$urandom}});
      step();
      if (i == 99) begin
        tests++; if (arb_if.stray_cnt_o !== 8'd102) begin fails++; $display("FAIL stray_mid: got %0d, required 102", arb_if.stray_cnt_o); end
      end
    end
    tests++; if (arb_if.stray_cnt_o !== 8'd255) begin fails++; $display("FAIL stray_saturate: got %0d, required 255", arb_if.stray_cnt_o); end
  endtask

  task automatic test_simul_grant_resp();
    fta_cmd_request128_t r;
    do_reset();
    r = mk_req(CMD_LOAD, 7'd20, 32'h0000_2000);
    arb_if.dc_req_i = r;
    exp_q.push_back(exp_req(r, DC_CID));
    step();
    r = mk_req(CMD_STORE, 7'd21, 32'h0000_2010);
    arb_if.dc_req_i = r;
    exp_q.push_back(exp_req(r, DC_CID));
    arb_if.ftam_resp = mk_resp(CORENO, DC_CID, 7'd20, 1'b1, 1'b0, {4{32'hC0DE_0020}});
    step();
    tests++; if (arb_if.ftam_req.tid.tranid !== 7'd21 || arb_if.dc_resp_o.tid.tranid !== 7'd20) begin fails++; $display("FAIL simul_both: got req %0d resp %0d, required 21 and 20", arb_if.ftam_req.tid.tranid, arb_if.dc_resp_o.tid.tranid); end
    // one still outstanding: three more fit, the fourth is held
    for (int i = 0; i < 4; i++) begin
      r = mk_req(CMD_LOAD, 7'(22 + i), 32'h0000_2100 + 32'(i * 16));
      arb_if.dc_req_i = r;
      if (i < 3) exp_q.push_back(exp_req(r, DC_CID));
      step();
    end
    tests++; if (arb_if.dc_busy_o !== 1'b1 || arb_if.ftam_req.cyc !== 1'b0) begin fails++; $display("FAIL simul_count: got busy %b cyc %b, required busy 1 cyc 0", arb_if.dc_busy_o, arb_if.ftam_req.cyc); end
    step();
  endtask

  task automatic test_busy_pulse();
    fta_cmd_request128_t ri, rd, rbad;
    logic [REQ_W-1:0] e;
    do_reset();
    ri = mk_req(CMD_LOAD, 7'd5, 32'h0000_A000);
    rd = mk_req(CMD_LOAD, 7'd6, 32'h0000_B000);
    e  = exp_req(ri, IC_CID);
    arb_if.ic_req_i = ri; arb_if.dc_req_i = rd;
    exp_q.push_back(exp_req(rd, DC_CID)); exp_q.push_back(e);
    step();
    tests++; if (arb_if.ic_busy_o !== 1'b1) begin fails++; $display("FAIL busy_set: got %b, required 1", arb_if.ic_busy_o); end
    rbad = mk_req(CMD_STORE, 7'd9, 32'h0000_C000);
    arb_if.ic_req_i = rbad;
    step();
    tests++; if (arb_if.ftam_req !== e) begin fails++; $display("FAIL busy_intact: got %h, required %h", arb_if.ftam_req, e); end
    step();
    tests++; if (arb_if.ftam_req.cyc !== 1'b0 || arb_if.ic_busy_o !== 1'b0) begin fails++; $display("FAIL busy_dropped: got cyc %b busy %b, required 0 0", arb_if.ftam_req.cyc, arb_if.ic_busy_o); end
    step();
  endtask

  task automatic test_reset_mid();
    fta_cmd_request128_t r;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      r = mk_req(CMD_ICACHE_LOAD, 7'(30 + i), 32'h0000_3000 + 32'(i * 16));
      arb_if.ic_req_i = r;
      exp_q.push_back(exp_req(r, IC_CID));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      r = mk_req(CMD_LOAD, 7'(40 + i), 32'h0000_4000 + 32'(i * 16));
      arb_if.dc_req_i = r;
      exp_q.push_back(exp_req(r, DC_CID));
      step();
    end
    arb_if.ic_req_i = mk_req(CMD_ICACHE_LOAD, 7'd50, 32'h0000_5000);
    arb_if.dc_req_i = mk_req(CMD_LOAD, 7'd51, 32'h0000_5100);
    step();
    tests++; if ({arb_if.ic_busy_o, arb_if.dc_busy_o} !== 2'b11) begin fails++; $display("FAIL mid_both_full: got %b%b, required 11", arb_if.ic_busy_o, arb_if.dc_busy_o); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL mid_pre_queue: got %0d left, required 0", exp_q.size()); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    tests++; if (arb_if.ftam_req !== '0 || arb_if.ic_resp_o !== '0 || arb_if.dc_resp_o !== '0) begin fails++; $display("FAIL mid_rst_outputs: got req %h, required 0", arb_if.ftam_req); end
    tests++; if ({arb_if.ic_busy_o, arb_if.dc_busy_o} !== 2'b00) begin fails++; $display("FAIL mid_rst_busy: got %b%b, required 00", arb_if.ic_busy_o, arb_if.dc_busy_o); end
    arb_if.ftam_resp = mk_resp(CORENO, IC_CID, 7'd30, 1'b1, 1'b0, {4{32'hFEED_0030}});
    step();
    tests++; if (arb_if.ic_resp_o.ack !== 1'b1 || arb_if.ic_resp_o.tid.tranid !== 7'd30) begin fails++; $display("FAIL mid_late_ic: got ack %b tranid %0d, required 1 30", arb_if.ic_resp_o.ack, arb_if.ic_resp_o.tid.tranid); end
    arb_if.ftam_resp = mk_resp(CORENO, DC_CID, 7'd40, 1'b1, 1'b0, {4{32'hFEED_0040}});
    step();
    tests++; if (arb_if.dc_resp_o.ack !== 1'b1 || arb_if.dc_resp_o.tid.tranid !== 7'd40) begin fails++; $display("FAIL mid_late_dc: got ack %b tranid %0d, required 1 40", arb_if.dc_resp_o.ack, arb_if.dc_resp_o.tid.tranid); end
    for (int i = 0; i < 5; i++) begin
      r = mk_req(CMD_LOAD, 7'(60 + i), 32'h0000_6000 + 32'(i * 16));
      arb_if.dc_req_i = r;
      if (i < 4) exp_q.push_back(exp_req(r, DC_CID));
      step();
      tests++; if (arb_if.dc_busy_o !== (i == 4)) begin fails++; $display("FAIL mid_refill_busy%0d: got %b, required %b", i, arb_if.dc_busy_o, (i == 4)); end
    end
    step();
  endtask

  initial begin
    arb_if.ic_req_i  = '0;
    arb_if.dc_req_i  = '0;
    arb_if.ftam_resp = '0;
    test_reset();
    test_single_ic();
    test_tie();
    test_out_limit();
    test_routing();
    test_simul_grant_resp();
    test_busy_pulse();
    test_reset_mid();
    step();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d expected requests never issued, required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
